register_bank: RTL and testbench
================================

// Module: register_bank
// PURPOSE
//  Parametrised bank of DEPTH general registers, each WIDTH bits, with in-place ops:
//  load, clear, increment, decrement, shift and rotate. Carry and zero flags are registered.
//  Serves as the CPU's register file, and its INC/DEC ops also cover PC and SP.
//  Two asynchronous read ports feed the ALU operand buses.
// PARAMETERS
//  WIDTH   8  bits per register (>=2)
//  DEPTH   4  number of registers (>=2; need not be a power of two)
//  ADDR_W  $clog2(DEPTH)  address width; derived, do not override
// PORTS
//  clk        in   1       single clock; all state changes on rising edge
//  rst_n      in   1       synchronous reset, active-low; sampled on rising clk
//  EI         in   1       enable; when low, op is ignored (no register/flag change)
//  op         in   3       operation code (see BEHAVIOUR)
//  wr_addr    in   ADDR_W  target register of op
//  data_in    in   WIDTH   load value for OP_LOAD
//  rd_addr_a  in   ADDR_W  read port A address
//  rd_addr_b  in   ADDR_W  read port B address
//  rd_data_a  out  WIDTH   contents of reg[rd_addr_a], combinational
//  rd_data_b  out  WIDTH   contents of reg[rd_addr_b], combinational
//  carry      out  1       registered carry/borrow/shift-out of last executed op
//  zero       out  1       registered: result of last executed op == 0
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all regs <= 0, carry <= 0, zero <= 0. Reset overrides EI/op.
//  - Op executes at the edge when rst_n=1 and EI=1. R = reg[wr_addr] before the edge.
//    0 NOP  : no change; flags hold
//    1 LOAD : R<=data_in; carry<=0
//    2 CLR  : R<=0; carry<=0
//    3 INC  : R<=R+1 mod 2^W; carry<=(R==all-ones)
//    4 DEC  : R<=R-1 mod 2^W; carry<=(R==0) (borrow)
//    5 SHL  : R<={R[W-2:0],0}; carry<=R[W-1]
//    6 SHR  : R<={0,R[W-1:1]}; carry<=R[0]
//    7 ROL  : R<={R[W-2:0],R[W-1]}; carry<=R[W-1]
//    zero<=(new R==0) for every executed non-NOP op.
//  - Latency: write visible on rd_data_* immediately after the edge. No same-cycle bypass;
//    a read of wr_addr during the op cycle returns the old value.
//  - Only reg[wr_addr] changes; every other register holds.
//  - wr_addr >= DEPTH: op is ignored and flags hold. rd_addr_* >= DEPTH: rd_data returns 0.
//  - rd_addr_a == rd_addr_b is legal; both ports return the same value.
//  - EI low or op=NOP: full state hold, including flags.
//  - Mid-operation reset is single-cycle: any op presented with rst_n=0 is discarded.
//  - Wrap-around is silent (INC all-ones -> 0, DEC 0 -> all-ones); only carry reports it.
//  - No #delays in RTL; nonblocking assignments only in the clocked process.
// STRUCTURE
//  - Shared package humanmachine_pkg: op localparams OP_NOP..OP_ROL (3-bit), OP_W=3.
//  - Sub-module register_op_unit (combinational, WIDTH param):
//    (op, R, data_in) -> (next_R, next_carry, next_zero).
//  - register_bank: storage array, write decode, read muxes, flag regs; instantiates one
//    register_op_unit on reg[wr_addr].
// TESTING (WIDTH=8, DEPTH=4 unless noted)
//  1 Reset: write reg1=0x5A, assert rst_n=0 for one edge -> all regs 0x00, carry=0, zero=0.
//  2 LOAD r2=0xFF, then INC r2 -> r2=0x00, carry=1, zero=1.
//    Then DEC r2 -> 0xFF, carry=1, zero=0.
//  3 LOAD r0=0x81: SHL -> 0x02, c=1; SHR -> 0x01, c=0; SHR -> 0x00, c=1, z=1;
//    LOAD 0x80 then ROL -> 0x01, c=1.
//  4 EI=0 with op=LOAD r3, data 0x33 -> r3 and flags unchanged.
//    Same-cycle read of r3 during an EI=1 load returns the old value; the new value appears next cycle.
//  5 DEPTH=3: LOAD wr_addr=3 -> no reg/flag change; rd_addr_a=3 -> rd_data_a=0x00.
//  6 Random op/addr stream vs reference model for 10k cycles, with rst_n pulsed at random
//    -> exact match of regs, carry and zero on every cycle.

Source files
------------

// File: rtl/humanmachine_pkg.sv
// Shared opcode definitions for the register bank and its op unit.
package humanmachine_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP  = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd1;
    localparam logic [OP_W-1:0] OP_CLR  = 3'd2;
    localparam logic [OP_W-1:0] OP_INC  = 3'd3;
    localparam logic [OP_W-1:0] OP_DEC  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd6;
    localparam logic [OP_W-1:0] OP_ROL  = 3'd7;

endpackage

// File: rtl/register_op_unit.sv
// Combinational datapath for one in-place register op: produces the new value
// and the carry/zero flags that result from it.
module register_op_unit
    import humanmachine_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] cur_r,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] next_r,
    output logic             next_carry,
    output logic             next_zero
);

    always_comb begin
        next_r     = cur_r;
        next_carry = 1'b0;
        case (op)
            OP_LOAD: next_r = data_in;
            OP_CLR:  next_r = '0;
            OP_INC: begin
                next_r     = cur_r + WIDTH'(1);
                next_carry = &cur_r;
            end
            OP_DEC: begin
                next_r     = cur_r - WIDTH'(1);
                next_carry = ~|cur_r;
            end
            OP_SHL: begin
                next_r     = {cur_r[WIDTH-2:0], 1'b0};
                next_carry = cur_r[WIDTH-1];
            end
            OP_SHR: begin
                next_r     = {1'b0, cur_r[WIDTH-1:1]};
                next_carry = cur_r[0];
            end
            OP_ROL: begin
                next_r     = {cur_r[WIDTH-2:0], cur_r[WIDTH-1]};
                next_carry = cur_r[WIDTH-1];
            end
            default: ;
        endcase
        next_zero = (next_r == '0);
    end

endmodule

// File: rtl/register_bank.sv
// Register file with in-place ops on reg[wr_addr], registered carry/zero flags
// and two combinational read ports (out-of-range addresses read as zero).
module register_bank
    import humanmachine_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              EI,
    input  logic [OP_W-1:0]   op,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              carry,
    output logic              zero
);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]            cur_r;
    logic [WIDTH-1:0]            next_r;
    logic                        next_carry;
    logic                        next_zero;
    logic                        wr_hit;
    logic                        exec;

    // Decode by comparison so a non-power-of-two DEPTH never indexes past the array.
    always_comb begin
        cur_r     = '0;
        wr_hit    = 1'b0;
        rd_data_a = '0;
        rd_data_b = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_addr == ADDR_W'(i)) begin
                cur_r  = regs[i];
                wr_hit = 1'b1;
            end
            if (rd_addr_a == ADDR_W'(i)) rd_data_a = regs[i];
            if (rd_addr_b == ADDR_W'(i)) rd_data_b = regs[i];
        end
    end

    assign exec = EI && (op != OP_NOP) && wr_hit;

    register_op_unit #(.WIDTH(WIDTH)) u_op (
        .op         (op),
        .cur_r      (cur_r),
        .data_in    (data_in),
        .next_r     (next_r),
        .next_carry (next_carry),
        .next_zero  (next_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs  <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (exec) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == ADDR_W'(i)) regs[i] <= next_r;
            end
            carry <= next_carry;
            zero  <= next_zero;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench: reference model feeds a scoreboard of expected outputs,
// plus a DEPTH=3 instance for out-of-range addressing.
module tb_register_bank;

    logic       clk = 1'b0;
    logic       rst_n, ei;
    logic [2:0] op;
    logic [1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [7:0] data_in, rd_data_a, rd_data_b;
    logic       carry, zero;

    logic       rst_n3, ei3;
    logic [2:0] op3;
    logic [1:0] wr_addr3, rd_addr_a3, rd_addr_b3;
    logic [7:0] data_in3, rd_data_a3, rd_data_b3;
    logic       carry3, zero3;

    always #5 clk = ~clk;

    register_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .EI(ei), .op(op), .wr_addr(wr_addr),
        .data_in(data_in), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .carry(carry), .zero(zero)
    );

    register_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n3), .EI(ei3), .op(op3), .wr_addr(wr_addr3),
        .data_in(data_in3), .rd_addr_a(rd_addr_a3), .rd_addr_b(rd_addr_b3),
        .rd_data_a(rd_data_a3), .rd_data_b(rd_data_b3), .carry(carry3), .zero(zero3)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic       z;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mreg[4];
    logic       mc, mz;
    logic [7:0] pre_a;
    int         checks = 0;
    int         errors = 0;

    // Applies stimulus at the falling edge, advances the model and queues the
    // outputs expected after the next rising edge. pre_a is the pre-edge read.
    task automatic drive(input logic r, input logic e, input logic [2:0] o,
                         input logic [1:0] wa, input logic [7:0] d,
                         input logic [1:0] ra, input logic [1:0] rb);
        logic [7:0] old, nr;
        logic       nc;
        exp_t       x;
        @(negedge clk);
        rst_n = r; ei = e; op = o; wr_addr = wa; data_in = d;
        rd_addr_a = ra; rd_addr_b = rb;
        pre_a = mreg[ra];
        old = mreg[wa];
        nr  = old;
        nc  = mc;
        case (o)
            3'd1: begin nr = d; nc = 1'b0; end
            3'd2: begin nr = 8'h00; nc = 1'b0; end
            3'd3: {nc, nr} = {1'b0, old} + 9'd1;
            3'd4: {nc, nr} = {1'b0, old} - 9'd1;
            3'd5: {nc, nr} = {old, 1'b0};
            3'd6: {nr, nc} = {1'b0, old};
            3'd7: begin nc = old[7]; nr = {old[6:0], old[7]}; end
            default: ;
        endcase
        if (!r) begin
            for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
            mc = 1'b0;
            mz = 1'b0;
        end else if (e && o != 3'd0) begin
            mreg[wa] = nr;
            mc = nc;
            mz = (nr == 8'h00);
        end
        x.a = mreg[ra];
        x.b = mreg[rb];
        x.c = mc;
        x.z = mz;
        sb.push_back(x);
    endtask

    task automatic test_reset();
        logic [2:0] tops[6] = '{3'd0, 3'd1, 3'd1, 3'd3, 3'd1, 3'd1};
        logic [1:0] tadr[6] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd2, 2'd1};
        logic [7:0] tdat[6] = '{8'h00, 8'h5A, 8'hFF, 8'h00, 8'h77, 8'h00};
        logic       trst[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_t       e;
        for (int k = 0; k < 6; k++) begin
            drive(trst[k], 1'b1, tops[k], tadr[k], tdat[k], 2'd1, tadr[k]);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 4;
            if (rd_data_a !== e.a) begin errors++; $display("FAIL reset[%0d] rd_a got %h exp %h", k, rd_data_a, e.a); end
            if (rd_data_b !== e.b) begin errors++; $display("FAIL reset[%0d] rd_b got %h exp %h", k, rd_data_b, e.b); end
            if (carry !== e.c) begin errors++; $display("FAIL reset[%0d] carry got %b exp %b", k, carry, e.c); end
            if (zero !== e.z) begin errors++; $display("FAIL reset[%0d] zero got %b exp %b", k, zero, e.z); end
        end
        for (int i = 0; i < 4; i++) begin
            rd_addr_a = 2'(i);
            #1;
            checks++;
            if (rd_data_a !== 8'h00) begin errors++; $display("FAIL reset_sweep r%0d got %h exp 00", i, rd_data_a); end
        end
    endtask

    // LOAD/INC/DEC wrap, then shifts and rotate on r0.
    task automatic test_ops();
        logic [2:0] tops[9] = '{3'd1, 3'd3, 3'd4, 3'd1, 3'd5, 3'd6, 3'd6, 3'd1, 3'd7};
        logic [1:0] tadr[9] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [7:0] tdat[9] = '{8'hFF, 8'h00, 8'h00, 8'h81, 8'h00, 8'h00, 8'h00, 8'h80, 8'h00};
        exp_t       e;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b1, tops[k], tadr[k], tdat[k], tadr[k], 2'd2);
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 4;
            if (rd_data_a !== e.a) begin errors++; $display("FAIL ops[%0d] rd_a got %h exp %h", k, rd_data_a, e.a); end
            if (rd_data_b !== e.b) begin errors++; $display("FAIL ops[%0d] rd_b got %h exp %h", k, rd_data_b, e.b); end
            if (carry !== e.c) begin errors++; $display("FAIL ops[%0d] carry got %b exp %b", k, carry, e.c); end
            if (zero !== e.z) begin errors++; $display("FAIL ops[%0d] zero got %b exp %b", k, zero, e.z); end
        end
    endtask

    // EI low and NOP must hold everything; same-cycle read sees the old value.
    task automatic test_enable_bypass();
        logic       tei[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [2:0] tops[5] = '{3'd1, 3'd3, 3'd1, 3'd0, 3'd1};
        logic [7:0] tdat[5] = '{8'h3C, 8'h00, 8'h33, 8'h99, 8'h77};
        exp_t       e;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, tei[k], tops[k], 2'd3, tdat[k], 2'd3, 2'd3);
            #1;
            checks++;
            if (rd_data_a !== pre_a) begin errors++; $display("FAIL bypass[%0d] pre-edge rd_a got %h exp %h", k, rd_data_a, pre_a); end
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 4;
            if (rd_data_a !== e.a) begin errors++; $display("FAIL enable[%0d] rd_a got %h exp %h", k, rd_data_a, e.a); end
            if (rd_data_b !== e.b) begin errors++; $display("FAIL enable[%0d] rd_b got %h exp %h", k, rd_data_b, e.b); end
            if (carry !== e.c) begin errors++; $display("FAIL enable[%0d] carry got %b exp %b", k, carry, e.c); end
            if (zero !== e.z) begin errors++; $display("FAIL enable[%0d] zero got %b exp %b", k, zero, e.z); end
        end
    endtask

    // DEPTH=3 instance: writes to address 3 are dropped, reads of 3 return 0.
    task automatic test_depth3();
        logic [2:0] tops[6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd3, 3'd1};
        logic [1:0] tadr[6] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd3};
        logic [7:0] tdat[6] = '{8'h00, 8'h11, 8'h22, 8'hFF, 8'h00, 8'h55};
        logic [7:0] rexp[4] = '{8'h11, 8'h22, 8'h00, 8'h00};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            rst_n3 = (k != 0); ei3 = 1'b1; op3 = tops[k]; wr_addr3 = tadr[k]; data_in3 = tdat[k];
        end
        @(posedge clk); #1;
        checks += 2;
        if (carry3 !== 1'b1) begin errors++; $display("FAIL depth3 carry got %b exp 1", carry3); end
        if (zero3 !== 1'b1) begin errors++; $display("FAIL depth3 zero got %b exp 1", zero3); end
        for (int i = 0; i < 4; i++) begin
            rd_addr_a3 = 2'(i);
            rd_addr_b3 = 2'(3 - i);
            #1;
            checks += 2;
            if (rd_data_a3 !== rexp[i]) begin errors++; $display("FAIL depth3 rd_a r%0d got %h exp %h", i, rd_data_a3, rexp[i]); end
            if (rd_data_b3 !== rexp[3-i]) begin errors++; $display("FAIL depth3 rd_b r%0d got %h exp %h", 3 - i, rd_data_b3, rexp[3-i]); end
        end
        @(negedge clk);
        op3 = 3'd0;
    endtask

    task automatic test_random();
        exp_t e;
        int   bad = 0;
        for (int k = 0; k < 10000; k++) begin
            drive(($urandom_range(31) != 0), ($urandom_range(7) != 0), 3'($urandom_range(7)),
                  2'($urandom_range(3)), 8'($urandom), 2'($urandom_range(3)), 2'($urandom_range(3)));
            @(posedge clk); #1;
            e = sb.pop_front();
            checks += 4;
            if (rd_data_a !== e.a) begin errors++; if (bad++ < 10) $display("FAIL random[%0d] rd_a got %h exp %h", k, rd_data_a, e.a); end
            if (rd_data_b !== e.b) begin errors++; if (bad++ < 10) $display("FAIL random[%0d] rd_b got %h exp %h", k, rd_data_b, e.b); end
            if (carry !== e.c) begin errors++; if (bad++ < 10) $display("FAIL random[%0d] carry got %b exp %b", k, carry, e.c); end
            if (zero !== e.z) begin errors++; if (bad++ < 10) $display("FAIL random[%0d] zero got %b exp %b", k, zero, e.z); end
        end
    endtask

    initial begin
        rst_n = 1'b0; ei = 1'b0; op = 3'd0; wr_addr = 2'd0; data_in = 8'h00;
        rd_addr_a = 2'd0; rd_addr_b = 2'd0;
        rst_n3 = 1'b0; ei3 = 1'b0; op3 = 3'd0; wr_addr3 = 2'd0; data_in3 = 8'h00;
        rd_addr_a3 = 2'd0; rd_addr_b3 = 2'd0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mc = 1'b0;
        mz = 1'b0;
        test_reset();
        test_ops();
        test_enable_bypass();
        test_depth3();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
